// File: rtl/reg_bank_burst_master_if.sv
// Bundle of all burst-master signals: command channel, write stream,
// read stream, completion pulse and the register-bank port wiring.
//   master modport : view of reg_bank_burst_master
//   slave  modport : view of the environment (command source, stream
//                    endpoints and the register bank itself)
interface reg_bank_burst_master_if #(
  parameter int unsigned BITS = 32
);

  localparam int unsigned AW = 4;

  // Command channel
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_write;
  logic [AW-1:0]   cmd_base;
  logic [AW-1:0]   cmd_len;

  // Write data stream
  logic            wr_valid;
  logic            wr_ready;
  logic [BITS-1:0] wr_data;

  // Read beat stream (register pair per beat)
  logic            rd_valid;
  logic            rd_ready;
  logic [BITS-1:0] rd_data1;
  logic [BITS-1:0] rd_data2;

  // Burst completion pulse
  logic            done;

  // Register bank ports
  logic            bank_we3;
  logic [AW-1:0]   bank_a1;
  logic [AW-1:0]   bank_a2;
  logic [AW-1:0]   bank_a3;
  logic [BITS-1:0] bank_wd3;
  logic [BITS-1:0] bank_rd1;
  logic [BITS-1:0] bank_rd2;

  modport master (
    input  cmd_valid, cmd_write, cmd_base, cmd_len,
    output cmd_ready,
    input  wr_valid, wr_data,
    output wr_ready,
    output rd_valid, rd_data1, rd_data2,
    input  rd_ready,
    output done,
    output bank_we3, bank_a1, bank_a2, bank_a3, bank_wd3,
    input  bank_rd1, bank_rd2
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_base, cmd_len,
    input  cmd_ready,
    output wr_valid, wr_data,
    input  wr_ready,
    input  rd_valid, rd_data1, rd_data2,
    output rd_ready,
    input  done,
    input  bank_we3, bank_a1, bank_a2, bank_a3, bank_wd3,
    output bank_rd1, bank_rd2
  );

endinterface

// File: rtl/reg_bank_burst_master.sv
// Initiator-side burst controller for a 16-entry register bank with one
// write port (WE3/A3/WD3) and two combinational read ports (A1/RD1, A2/RD2).
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low reset; abandons any burst in flight
//   io_bus   : master modport carrying
//     cmd_*   valid/ready burst command (write flag, base address, len-1)
//     wr_*    write word stream, one register per accepted word
//     rd_*    registered, backpressured read beats (REGS[a], REGS[a+1])
//     done    one-cycle pulse per completed burst
//     bank_*  register bank connections
module reg_bank_burst_master #(
  parameter int unsigned BITS = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  reg_bank_burst_master_if.master io_bus
);

  localparam int unsigned AW = 4;
  // One extra bit so a 16-transfer burst count fits
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [AW-1:0]   r_addr;
  logic [CW-1:0]   r_remaining;
  logic [BITS-1:0] r_rd_data1;
  logic [BITS-1:0] r_rd_data2;
  logic            r_rd_valid;
  logic            r_done;

  logic            w_cmd_ready;
  logic            w_wr_ready;
  logic            w_cmd_fire;
  logic            w_wr_fire;
  logic            w_wr_last;
  logic            w_rd_load;
  logic            w_rd_drain;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (io_bus.cmd_valid) begin
          w_state_nxt = io_bus.cmd_write ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        if (w_wr_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_READ: begin
        if (w_rd_drain) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output / strobe decode
  always_comb begin
    w_cmd_ready = 1'b0;
    w_wr_ready  = 1'b0;
    w_cmd_fire  = 1'b0;
    w_wr_fire   = 1'b0;
    w_wr_last   = 1'b0;
    w_rd_load   = 1'b0;
    w_rd_drain  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_cmd_ready = 1'b1;
        w_cmd_fire  = io_bus.cmd_valid;
      end
      S_WRITE: begin
        w_wr_ready = 1'b1;
        w_wr_fire  = io_bus.wr_valid & w_wr_ready;
        w_wr_last  = w_wr_fire && (r_remaining == CW'(1));
      end
      S_READ: begin
        // Refill the output register whenever it is empty or being consumed
        w_rd_load  = (r_remaining != CW'(0)) && (!r_rd_valid || io_bus.rd_ready);
        // Final beat consumed with nothing left to fetch
        w_rd_drain = r_rd_valid && io_bus.rd_ready && (r_remaining == CW'(0));
      end
      default: begin
        w_cmd_ready = 1'b0;
      end
    endcase
  end

  // Burst address/count and registered read stream
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr      <= AW'(0);
      r_remaining <= CW'(0);
      r_rd_data1  <= BITS'(0);
      r_rd_data2  <= BITS'(0);
      r_rd_valid  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_cmd_fire) begin
        r_addr      <= io_bus.cmd_base;
        r_remaining <= CW'(io_bus.cmd_len) + CW'(1);
      end

      if (w_wr_fire) begin
        r_addr      <= r_addr + AW'(1);
        r_remaining <= r_remaining - CW'(1);
        if (w_wr_last) begin
          r_done <= 1'b1;
        end
      end

      if (w_rd_load) begin
        r_rd_data1  <= io_bus.bank_rd1;
        r_rd_data2  <= io_bus.bank_rd2;
        r_rd_valid  <= 1'b1;
        r_addr      <= r_addr + AW'(2);
        r_remaining <= r_remaining - CW'(1);
      end else if (w_rd_drain) begin
        r_rd_valid <= 1'b0;
        r_done     <= 1'b1;
      end
    end
  end

  // Bank address ports follow the burst pointer; addition wraps mod 16
  assign io_bus.bank_a1  = r_addr;
  assign io_bus.bank_a2  = r_addr + AW'(1);
  assign io_bus.bank_a3  = r_addr;
  assign io_bus.bank_wd3 = io_bus.wr_data;
  // Write strobe is the handshake itself so the word lands on the same edge
  assign io_bus.bank_we3 = w_wr_fire;

  assign io_bus.cmd_ready = w_cmd_ready;
  assign io_bus.wr_ready  = w_wr_ready;
  assign io_bus.rd_valid  = r_rd_valid;
  assign io_bus.rd_data1  = r_rd_data1;
  assign io_bus.rd_data2  = r_rd_data2;
  assign io_bus.done      = r_done;

endmodule

// File: doc/reg_bank_burst_master.md
Name: reg_bank_burst_master

Overview:
- Initiator-side controller for the 16-entry register bank (4-bit addresses, one write port WE3/A3/WD3, two combinational read ports A1/RD1, A2/RD2).
- Accepts burst commands over a valid/ready handshake.
- Write bursts: streams incoming words into consecutive registers.
- Read bursts: fetches register pairs for the vector datapath through a registered, backpressured output stream.

Parameters:
- BITS, 32, data word width; must match the bank's BITS.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- CMD_VALID  in  1  command offered.
- CMD_READY  out  1  command accepted when high with CMD_VALID.
- CMD_WRITE  in  1  1 = write burst, 0 = read burst.
- CMD_BASE  in  4  first register address.
- CMD_LEN  in  4  transfers minus 1 (1..16 transfers).
- WR_VALID  in  1  write word offered.
- WR_READY  out  1  write word accepted.
- WR_DATA  in  BITS  write word.
- RD_VALID  out  1  read beat available.
- RD_READY  in  1  consumer accepts beat.
- RD_DATA1  out  BITS  REGS[addr] of the beat.
- RD_DATA2  out  BITS  REGS[addr+1] of the beat.
- DONE  out  1  one-cycle pulse at burst completion.
- BANK_WE3  out  1  to bank WE3.
- BANK_A1  out  4  to bank A1.
- BANK_A2  out  4  to bank A2.
- BANK_A3  out  4  to bank A3.
- BANK_WD3  out  BITS  to bank WD3.
- BANK_RD1  in  BITS  from bank RD1.
- BANK_RD2  in  BITS  from bank RD2.

Behaviour:
- Reset (async, RST_N=0):
  - State IDLE; addr=0, remaining=0.
  - RD_VALID=0, RD_DATA1=RD_DATA2=0, DONE=0.
  - Reset mid-burst abandons the burst; no further BANK_WE3 after reset asserts.
- Address and port rules:
  - All address arithmetic is modulo 16 (4-bit wrap; 15+1 -> 0).
  - BANK_A1=addr, BANK_A2=addr+1, BANK_A3=addr.
  - BANK_WD3=WR_DATA.
- IDLE:
  - CMD_READY=1, WR_READY=0.
  - On CMD_VALID: latch addr=CMD_BASE, remaining=CMD_LEN+1.
  - Go to WRITE if CMD_WRITE=1, else READ.
- WRITE:
  - WR_READY=1, CMD_READY=0.
  - BANK_WE3 = WR_VALID & WR_READY (combinational), so the word lands in the bank at the same clock edge as the handshake.
  - Per handshake: addr+=1, remaining-=1.
  - On the handshake with remaining=1: DONE pulses the next cycle, go to IDLE.
  - WR_VALID low stalls indefinitely with no writes.
- READ:
  - CMD_READY=0, WR_READY=0, BANK_WE3=0.
  - Load condition: remaining>0 and (RD_VALID=0 or RD_READY=1).
  - On load, the output register captures BANK_RD1/BANK_RD2 and RD_VALID=1 next cycle; then addr+=2, remaining-=1.
  - Throughput: one beat per cycle while RD_READY is held high.
  - Hold: RD_VALID=1 and RD_READY=0 keeps RD_DATA1/2 and RD_VALID stable.
  - If RD_VALID=1, RD_READY=1 and remaining=0: RD_VALID clears next cycle, DONE pulses that cycle, go to IDLE.
  - The last beat is consumed before the next command is accepted.
- DONE:
  - Asserted exactly one cycle per burst.
  - CMD_READY rises in the same cycle as DONE.
- Write-burst wrap (base 15, len 1): writes regs 15 then 0.
- Read-pair wrap: addr 15 reads RD1=REGS[15], RD2=REGS[0].
- CMD_VALID while not in IDLE is ignored (CMD_READY=0).

Test Plan:
- Reset with RST_N low mid READ burst, asynchronously -> RD_VALID=0, DONE=0, CMD_READY=1 within the same cycle after release; no BANK_WE3 pulses.
- Write burst base=2, LEN=3, data 0x11,0x22,0x33,0x44 with WR_VALID gapped every other cycle -> BANK_WE3 pulses exactly 4 times at A3=2,3,4,5; DONE one cycle after the 4th handshake.
- Bench bank preloaded REGS[0]=65536, REGS[1]=81928, REGS[2]=7, REGS[3]=9; read base=0, LEN=1, RD_READY=1 -> beats (65536,81928) then (7,9) on consecutive cycles; DONE once.
- Same read with RD_READY low for 3 cycles after first RD_VALID -> RD_DATA stable at (65536,81928) throughout; second beat follows the first accepting cycle.
- Write base=15, LEN=1 (0xAA,0xBB) then read base=15, LEN=0 -> REGS[15]=0xAA, REGS[0]=0xBB; read beat (0xAA,0xBB).
- CMD_VALID held high during an active write burst with a different command -> ignored; the new command is accepted only in the cycle DONE pulses.
